// File: rtl/pu_msp430_scan_unload_if.sv
// Bus bundle for the scan-chain unload engine. The bench drives the master side
// and the engine itself uses the slave side.
interface pu_msp430_scan_unload_if #(
  parameter int WIDTH = 16
);
  logic             scan_mode;
  logic             cap_req;
  logic [WIDTH-1:0] cap_data;
  logic             scan_in;
  logic             scan_out;
  logic             scan_en;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] shift_word;
  logic [1:0]       fsm_state;

  // Handshake: cap_req is a request with no ready line. It is sampled only in IDLE,
  // and only when scan_mode=1; while busy or done=1 it is dropped, not queued.
  // done is a single-cycle valid that qualifies shift_word.
  modport master (
    output scan_mode, cap_req, cap_data, scan_in,
    input  scan_out, scan_en, busy, done, shift_word, fsm_state
  );

  modport slave (
    input  scan_mode, cap_req, cap_data, scan_in,
    output scan_out, scan_en, busy, done, shift_word, fsm_state
  );
endinterface

// File: rtl/pu_msp430_scan_unload.sv
// Scan-chain unload engine: captures a parallel word and shifts it out LSB first,
// while shifting scan_in into the MSB. fsm_state exposes the registered FSM state.
module pu_msp430_scan_unload #(
  parameter int WIDTH     = 16,
  parameter int SHIFT_DIV = 1
) (
  input  logic                          mclk,
  input  logic                          puc_rst,
  pu_msp430_scan_unload_if.slave        bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_SHIFT   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int DIV_W = (SHIFT_DIV > 1) ? $clog2(SHIFT_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_cnt;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else if (state != ST_IDLE && !bus.scan_mode) begin
      // Abort: drop back to IDLE, keep the partially shifted word.
      state   <= ST_IDLE;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.scan_mode && bus.cap_req) begin
            state <= ST_CAPTURE;
            shreg <= bus.cap_data;
          end
        end
        ST_CAPTURE: begin
          state   <= ST_SHIFT;
          bit_cnt <= '0;
          div_cnt <= '0;
        end
        ST_SHIFT: begin
          // Shift only on the last cycle of each bit period.
          if (div_cnt == DIV_LAST) begin
            shreg   <= {bus.scan_in, shreg[WIDTH-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            div_cnt <= '0;
            if (bit_cnt == BIT_LAST) state <= ST_DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.scan_en    = (state == ST_SHIFT);
  assign bus.busy       = (state == ST_CAPTURE) || (state == ST_SHIFT);
  assign bus.done       = (state == ST_DONE);
  assign bus.scan_out   = bus.scan_en & shreg[0];
  assign bus.shift_word = shreg;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_pu_msp430_scan_unload.sv
// Bench for pu_msp430_scan_unload: two instances (SHIFT_DIV=1 and 3) driven by
// randomized unloads, checked by a queue-based scoreboard and an independent monitor.
module tb_pu_msp430_scan_unload;
  localparam int W = 16;

  // clock / reset
  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  pu_msp430_scan_unload_if #(.WIDTH(W)) bus0 ();
  pu_msp430_scan_unload_if #(.WIDTH(W)) bus1 ();

  pu_msp430_scan_unload #(.WIDTH(W), .SHIFT_DIV(1)) dut0 (
    .mclk(mclk), .puc_rst(rst), .bus(bus0.slave));
  pu_msp430_scan_unload #(.WIDTH(W), .SHIFT_DIV(3)) dut1 (
    .mclk(mclk), .puc_rst(rst), .bus(bus1.slave));

  logic         mode_v[2];
  logic         req_v[2];
  logic         si_v[2];
  logic         loop_v[2];
  logic [W-1:0] data_v[2];

  assign bus0.scan_mode = mode_v[0];
  assign bus0.cap_req   = req_v[0];
  assign bus0.cap_data  = data_v[0];
  assign bus0.scan_in   = loop_v[0] ? bus0.scan_out : si_v[0];
  assign bus1.scan_mode = mode_v[1];
  assign bus1.cap_req   = req_v[1];
  assign bus1.cap_data  = data_v[1];
  assign bus1.scan_in   = loop_v[1] ? bus1.scan_out : si_v[1];

  logic         so_v[2], en_v[2], busy_v[2], done_v[2];
  logic [W-1:0] word_v[2];
  assign so_v[0] = bus0.scan_out;   assign so_v[1] = bus1.scan_out;
  assign en_v[0] = bus0.scan_en;    assign en_v[1] = bus1.scan_en;
  assign busy_v[0] = bus0.busy;     assign busy_v[1] = bus1.busy;
  assign done_v[0] = bus0.done;     assign done_v[1] = bus1.done;
  assign word_v[0] = bus0.shift_word; assign word_v[1] = bus1.shift_word;

  // scoreboard
  int           n_checks = 0;
  int           n_fail   = 0;
  int           act      = 0;
  logic         exp_bit_q[$];
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // monitor
  always @(negedge mclk) begin
    logic         b;
    logic [W-1:0] w;
    int           c;
    if (!rst) begin
      for (int s = 0; s < 2; s++) begin
        if (en_v[s]) begin
          if (s != act || exp_bit_q.size() == 0) begin
            check("stray_scan_en", 32'(s), 32'hFFFF);
          end else begin
            b = exp_bit_q.pop_front();
            check("scan_out", 32'(so_v[s]), 32'(b));
            check("busy_in_shift", 32'(busy_v[s]), 32'd1);
          end
        end
        if (done_v[s]) begin
          if (s != act || exp_q.size() == 0) begin
            check("stray_done", 32'(s), 32'hFFFF);
          end else begin
            w = exp_q.pop_front();
            c = exp_cyc_q.pop_front();
            check("shift_word", 32'(word_v[s]), 32'(w));
            check("done_cycle", 32'(cyc), 32'(c));
            check("busy_in_done", 32'(busy_v[s]), 32'd0);
          end
        end
      end
    end
  end

  // driver: smode 0=random scan_in, 1=loopback, 2=all ones, 3=all zeros
  // stop_kind 0=complete, 1=scan_mode drop at stop_bit, 2=reset at stop_bit
  task automatic unload(input int s, input logic [W-1:0] d, input int smode,
                        input int stop_bit, input int stop_kind, input bit poke);
    int           div;
    logic [W-1:0] sv;
    logic [W-1:0] part;
    div = (s == 1) ? 3 : 1;
    act = s;
    for (int i = 0; i < W; i++) begin
      case (smode)
        0:       sv[i] = 1'($urandom_range(0, 1));
        1:       sv[i] = d[i];
        2:       sv[i] = 1'b1;
        default: sv[i] = 1'b0;
      endcase
    end
    loop_v[s] = (smode == 1);
    data_v[s] = d;
    si_v[s]   = 1'b0;
    req_v[s]  = 1'b1;
    @(posedge mclk); #1;
    req_v[s] = 1'b0;
    if (stop_kind == 0) begin
      // Incoming bit i is sampled i-th, so it ends up in word bit i.
      exp_q.push_back(sv);
      exp_cyc_q.push_back(cyc + W * div + 1);
    end
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < div; j++) begin
        @(posedge mclk); #1;
        req_v[s] = 1'b0;
        if (j == 0) si_v[s] = sv[i];
        if (i == stop_bit && j == 0 && stop_kind == 1) begin
          exp_bit_q.push_back(d[i]);
          mode_v[s] = 1'b0;
          part = (d >> i) | (sv << (W - i));
          @(posedge mclk); #1;
          check("abort_scan_en", 32'(en_v[s]), 32'd0);
          check("abort_busy", 32'(busy_v[s]), 32'd0);
          check("abort_done", 32'(done_v[s]), 32'd0);
          check("abort_word", 32'(word_v[s]), 32'(part));
          mode_v[s] = 1'b1;
          loop_v[s] = 1'b0;
          return;
        end
        if (i == stop_bit && j == 0 && stop_kind == 2) begin
          #1 rst = 1'b1;
          #1;
          check("rst_scan_out", 32'(so_v[s]), 32'd0);
          check("rst_scan_en", 32'(en_v[s]), 32'd0);
          check("rst_busy", 32'(busy_v[s]), 32'd0);
          check("rst_done", 32'(done_v[s]), 32'd0);
          check("rst_word", 32'(word_v[s]), 32'd0);
          exp_bit_q.delete();
          #1 rst = 1'b0;
          loop_v[s] = 1'b0;
          return;
        end
        exp_bit_q.push_back(d[i]);
        if (poke && i == 7 && j == 0) req_v[s] = 1'b1;
      end
    end
    @(posedge mclk); #1;
    req_v[s] = 1'b0;
    if (poke) req_v[s] = 1'b1;
    @(posedge mclk); #1;
    req_v[s]  = 1'b0;
    loop_v[s] = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      mode_v[s] = 1'b1; req_v[s] = 1'b0; si_v[s] = 1'b0;
      loop_v[s] = 1'b0; data_v[s] = '0;
    end
    #1;
    check("reset_scan_out", 32'(so_v[0]), 32'd0);
    check("reset_scan_en", 32'(en_v[0]), 32'd0);
    check("reset_busy", 32'(busy_v[1]), 32'd0);
    check("reset_done", 32'(done_v[1]), 32'd0);
    check("reset_word", 32'(word_v[0]), 32'd0);
    repeat (2) @(posedge mclk);
    #2 rst = 1'b0;

    unload(0, 16'hA5C3, 3, -1, 0, 1'b0);
    unload(0, 16'h1234, 1, -1, 0, 1'b0);
    unload(0, 16'h0F0F, 2, -1, 0, 1'b0);
    unload(1, 16'h0001, 3, -1, 0, 1'b0);
    unload(0, 16'($urandom), 0, -1, 0, 1'b1);
    unload(0, 16'($urandom), 0, 5, 1, 1'b0);
    unload(0, 16'($urandom), 0, -1, 0, 1'b0);
    unload(0, 16'($urandom), 0, 9, 2, 1'b0);
    unload(0, 16'($urandom), 0, -1, 0, 1'b0);

    // scan_mode low in IDLE must block a capture
    act = 0;
    mode_v[0] = 1'b0;
    req_v[0]  = 1'b1;
    repeat (3) begin
      @(posedge mclk); #1;
      check("no_cap_without_mode", 32'(busy_v[0]), 32'd0);
    end
    req_v[0]  = 1'b0;
    mode_v[0] = 1'b1;

    for (int n = 0; n < 6; n++)
      unload(n % 2, 16'($urandom), int'($urandom_range(0, 3)), -1, 0,
             1'($urandom_range(0, 1)));
    unload(1, 16'($urandom), 0, 4, 1, 1'b0);
    unload(1, 16'($urandom), 1, -1, 0, 1'b1);

    repeat (4) @(posedge mclk);
    #1;
    check("bits_drained", 32'(exp_bit_q.size()), 32'd0);
    check("words_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
